rr_mult_pipe: RTL and testbench

Parametrised, pipelined recursive (rr) unsigned multiplier with valid/ready handshake: the sequential successor to the fixed-width combinational rr4x4/rr3x3 blocks. It splits each operand into a high part of WIDTH−SPLIT bits and a low part of SPLIT bits, forms the four exact sub-products, and sums them in a registered tree. A per-transaction approximate mode drops the low×low term. The block sits between an operand source and a result sink in the NSGA evaluation harness, carries a user tag, and counts completed products.

---
 rtl/rr_mult_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_rr_mult_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mult_pipe.sv
// rr_mult_pipe -- pipelined recursive unsigned multiplier with valid/ready.
//
// Each operand is split into a high part (WIDTH-SPLIT bits) and a low part
// (SPLIT bits). The four exact sub-products are formed in stage 2 and summed
// in stage 3. Setting in_approx_i for a beat drops the low x low term of that
// beat only. A user tag travels with each beat. done_cnt_o counts the results
// taken by the sink.
//
// Pipeline: S1 (operands) -> S2 (sub-products) -> S3 (sum, drives outputs).
// The whole pipe advances together whenever the output register is empty or
// is being drained. Bubbles are kept in place, so a stall freezes every stage.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid_i   operand beat valid
//   in_ready_o   block accepts a beat this cycle
//   in_a_i       multiplicand, WIDTH bits
//   in_b_i       multiplier, WIDTH bits
//   in_approx_i  1 = drop the low x low sub-product for this beat
//   in_tag_i     tag returned with the result
//   out_valid_o  result valid
//   out_ready_i  sink takes the result this cycle
//   out_p_o      product, 2*WIDTH bits
//   out_tag_o    tag of the beat that produced out_p_o
//   done_cnt_o   results taken by the sink, modulo 2^CNT_W
module rr_mult_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SPLIT = 1,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     in_a_i,
  input  logic [WIDTH-1:0]     in_b_i,
  input  logic                 in_approx_i,
  input  logic [TAG_W-1:0]     in_tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*WIDTH-1:0]   out_p_o,
  output logic [TAG_W-1:0]     out_tag_o,
  output logic [CNT_W-1:0]     done_cnt_o
);

  localparam int unsigned H    = WIDTH - SPLIT;
  localparam int unsigned L    = SPLIT;
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned HH_W = 2 * H;
  localparam int unsigned X_W  = H + L;
  localparam int unsigned LL_W = 2 * L;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  // Stage 1: operands
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_approx_q, s1_approx_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  // Stage 2: sub-products
  logic             s2_valid_q, s2_valid_d;
  logic [HH_W-1:0]  hh_q, hh_d;
  logic [X_W-1:0]   hl_q, hl_d;
  logic [X_W-1:0]   lh_q, lh_d;
  logic [LL_W-1:0]  ll_q, ll_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  // Stage 3: result
  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    out_p_q, out_p_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic             adv_s;
  logic [H-1:0]     ah_s, bh_s;
  logic [L-1:0]     al_s, bl_s;
  logic [HH_W-1:0]  hh_s;
  logic [X_W-1:0]   hl_s, lh_s;
  logic [LL_W-1:0]  ll_s;
  logic [PW-1:0]    sum_s;

  // Whole-pipe advance: the output slot is free or is being drained now.
  assign adv_s      = !out_valid_q || out_ready_i;
  assign in_ready_o = adv_s;

  assign ah_s = s1_a_q[WIDTH-1:L];
  assign al_s = s1_a_q[L-1:0];
  assign bh_s = s1_b_q[WIDTH-1:L];
  assign bl_s = s1_b_q[L-1:0];

  // Exact sub-products of the stage-1 operands; approx zeroes LL here.
  always_comb begin
    hh_s = HH_W'(ah_s) * HH_W'(bh_s);
    hl_s = X_W'(ah_s) * X_W'(bl_s);
    lh_s = X_W'(al_s) * X_W'(bh_s);
    if (s1_approx_q) begin
      ll_s = {LL_W{1'b0}};
    end else begin
      ll_s = LL_W'(al_s) * LL_W'(bl_s);
    end
  end

  // Recombination at full product width; the cross terms are widened
  // before adding so their carry is kept.
  assign sum_s = (PW'(hh_q) << LL_W)
               + ((PW'(hl_q) + PW'(lh_q)) << L)
               + PW'(ll_q);

  // Next state for every stage: load from predecessor on advance, else hold.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_approx_d = s1_approx_q;
    s1_tag_d    = s1_tag_q;
    s2_valid_d  = s2_valid_q;
    hh_d        = hh_q;
    hl_d        = hl_q;
    lh_d        = lh_q;
    ll_d        = ll_q;
    s2_tag_d    = s2_tag_q;
    out_valid_d = out_valid_q;
    out_p_d     = out_p_q;
    out_tag_d   = out_tag_q;
    if (adv_s) begin
      s1_valid_d  = in_valid_i;
      s1_a_d      = in_a_i;
      s1_b_d      = in_b_i;
      s1_approx_d = in_approx_i;
      s1_tag_d    = in_tag_i;
      s2_valid_d  = s1_valid_q;
      hh_d        = hh_s;
      hl_d        = hl_s;
      lh_d        = lh_s;
      ll_d        = ll_s;
      s2_tag_d    = s1_tag_q;
      out_valid_d = s2_valid_q;
      out_p_d     = sum_s;
      out_tag_d   = s2_tag_q;
    end else begin
      // stalled: every stage, bubbles included, keeps its contents
      out_valid_d = out_valid_q;
    end
  end

  // Completed-product counter, wraps naturally at 2^CNT_W.
  always_comb begin
    if (out_valid_q && out_ready_i) begin
      done_cnt_d = done_cnt_q + CNT_ONE;
    end else begin
      done_cnt_d = done_cnt_q;
    end
  end

  // State registers; reset discards all in-flight beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= {WIDTH{1'b0}};
      s1_b_q      <= {WIDTH{1'b0}};
      s1_approx_q <= 1'b0;
      s1_tag_q    <= {TAG_W{1'b0}};
      s2_valid_q  <= 1'b0;
      hh_q        <= {HH_W{1'b0}};
      hl_q        <= {X_W{1'b0}};
      lh_q        <= {X_W{1'b0}};
      ll_q        <= {LL_W{1'b0}};
      s2_tag_q    <= {TAG_W{1'b0}};
      out_valid_q <= 1'b0;
      out_p_q     <= {PW{1'b0}};
      out_tag_q   <= {TAG_W{1'b0}};
      done_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_approx_q <= s1_approx_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      hh_q        <= hh_d;
      hl_q        <= hl_d;
      lh_q        <= lh_d;
      ll_q        <= ll_d;
      s2_tag_q    <= s2_tag_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      out_tag_q   <= out_tag_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_p_o     = out_p_q;
  assign out_tag_o   = out_tag_q;
  assign done_cnt_o  = done_cnt_q;

endmodule

// File: tb/tb_rr_mult_pipe.sv
// Bench for rr_mult_pipe. Instance A: WIDTH=8, SPLIT=3 checked through a
// scoreboard under several out_ready patterns. Instance B: WIDTH=4, SPLIT=1,
// CNT_W=2 checked directly for latency, small products and counter wrap.
module tb_rr_mult_pipe;

  logic clk;
  logic rst_n;

  logic        a_in_valid, a_in_ready, a_in_approx, a_out_valid, a_out_ready;
  logic [7:0]  a_in_a, a_in_b;
  logic [3:0]  a_in_tag, a_out_tag;
  logic [15:0] a_out_p, a_done_cnt;

  logic        b_in_valid, b_in_ready, b_in_approx, b_out_valid, b_out_ready;
  logic [3:0]  b_in_a, b_in_b, b_in_tag, b_out_tag;
  logic [7:0]  b_out_p;
  logic [1:0]  b_done_cnt;

  typedef struct packed {
    logic [15:0] p;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   n_err     = 0;
  int   n_chk     = 0;
  int   a_retired = 0;
  int   rdy_mode  = 0;
  int   pat_cnt   = 0;

  rr_mult_pipe #(.WIDTH(8), .SPLIT(3), .TAG_W(4), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .in_a_i(a_in_a), .in_b_i(a_in_b), .in_approx_i(a_in_approx), .in_tag_i(a_in_tag),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .out_p_o(a_out_p), .out_tag_o(a_out_tag), .done_cnt_o(a_done_cnt)
  );

  rr_mult_pipe #(.WIDTH(4), .SPLIT(1), .TAG_W(4), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .in_a_i(b_in_a), .in_b_i(b_in_b), .in_approx_i(b_in_approx), .in_tag_i(b_in_tag),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .out_p_o(b_out_p), .out_tag_o(b_out_tag), .done_cnt_o(b_done_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: exact product minus the low x low term when approximating.
  function automatic logic [15:0] model_a(input logic [7:0] a, input logic [7:0] b, input logic ap);
    logic [15:0] full;
    logic [15:0] ll;
    full = 16'(a) * 16'(b);
    ll   = 16'(a[2:0]) * 16'(b[2:0]);
    return ap ? (full - ll) : full;
  endfunction

  // out_ready pattern for instance A: 0 = always, 1 = 1,0,0 repeating, 2 = random.
  initial begin
    a_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin
          a_out_ready = ((pat_cnt % 3) == 0);
          pat_cnt++;
        end
        2:       a_out_ready = 1'($urandom_range(0, 1));
        default: a_out_ready = 1'b1;
      endcase
    end
  end

  // Output monitor for A, sampled mid-cycle; the head of the scoreboard must
  // be on the output whenever out_valid is high, stalled or not.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else if (a_out_valid) begin
      if (sb.size() == 0) begin
        check_eq("a_spurious_out", 64'(a_out_valid), 64'(0));
      end else begin
        check_eq("a_out_p", 64'(a_out_p), 64'(sb[0].p));
        check_eq("a_out_tag", 64'(a_out_tag), 64'(sb[0].tag));
        if (a_out_ready) begin
          void'(sb.pop_front());
          a_retired++;
        end
      end
      if (!a_out_ready) check_eq("a_stall_in_ready", 64'(a_in_ready), 64'(0));
    end
  end

  // Present one beat to A and hold it until accepted; record its expectation.
  task automatic a_send(input logic [7:0] a, input logic [7:0] b, input logic ap,
                        input logic [3:0] tag, input logic [15:0] exp_p);
    bit   fired = 1'b0;
    exp_t e;
    a_in_valid  = 1'b1;
    a_in_a      = a;
    a_in_b      = b;
    a_in_approx = ap;
    a_in_tag    = tag;
    for (int k = 0; k < 1000 && !fired; k++) begin
      @(negedge clk);
      fired = a_in_ready;
      @(posedge clk);
      #1;
    end
    if (fired) begin
      e.p   = exp_p;
      e.tag = tag;
      sb.push_back(e);
    end else begin
      check_eq("a_accept_timeout", 64'(0), 64'(1));
    end
  endtask

  task automatic a_idle();
    a_in_valid  = 1'b0;
    a_in_approx = 1'($urandom_range(0, 1));
    a_in_tag    = 4'($urandom_range(0, 15));
  endtask

  task automatic a_drain();
    int k = 0;
    while (sb.size() != 0 && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (sb.size() != 0) check_eq("a_drain_timeout", 64'(sb.size()), 64'(0));
  endtask

  // One beat through B: the acceptance edge loads S1, so out_valid rises
  // after the third edge counting that one, and retires on the fourth.
  task automatic run_b(input logic [3:0] a, input logic [3:0] b, input logic ap,
                       input logic [3:0] tag, input logic [7:0] exp_p, input logic [1:0] exp_cnt);
    b_in_valid  = 1'b1;
    b_in_a      = a;
    b_in_b      = b;
    b_in_approx = ap;
    b_in_tag    = tag;
    check_eq("b_in_ready", 64'(b_in_ready), 64'(1));
    @(posedge clk);
    #1;
    b_in_valid  = 1'b0;
    b_in_approx = ~ap;
    b_in_tag    = ~tag;
    b_in_a      = ~a;
    check_eq("b_lat1_valid", 64'(b_out_valid), 64'(0));
    @(posedge clk);
    #1;
    check_eq("b_lat2_valid", 64'(b_out_valid), 64'(0));
    @(posedge clk);
    #1;
    check_eq("b_lat3_valid", 64'(b_out_valid), 64'(1));
    check_eq("b_out_p", 64'(b_out_p), 64'(exp_p));
    check_eq("b_out_tag", 64'(b_out_tag), 64'(tag));
    @(posedge clk);
    #1;
    check_eq("b_done_cnt", 64'(b_done_cnt), 64'(exp_cnt));
  endtask

  initial begin
    logic [3:0] ta [5] = '{4'd15, 4'd15, 4'd6, 4'd10, 4'd7};
    logic [3:0] tb [5] = '{4'd15, 4'd15, 4'd9, 4'd13, 4'd7};
    logic       tap[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] tt [5] = '{4'd3, 4'd5, 4'd9, 4'd12, 4'd6};
    logic [7:0] tp [5] = '{8'd225, 8'd224, 8'd54, 8'd130, 8'd48};
    logic [1:0] tc [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [7:0] ra, rb;
    logic       rap;
    logic [3:0] rt;

    rst_n       = 1'b0;
    a_in_valid  = 1'b0;
    a_in_a      = 8'd0;
    a_in_b      = 8'd0;
    a_in_approx = 1'b0;
    a_in_tag    = 4'd0;
    b_in_valid  = 1'b0;
    b_in_a      = 4'd0;
    b_in_b      = 4'd0;
    b_in_approx = 1'b0;
    b_in_tag    = 4'd0;
    b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_a_out_valid", 64'(a_out_valid), 64'(0));
    check_eq("rst_a_out_p", 64'(a_out_p), 64'(0));
    check_eq("rst_a_out_tag", 64'(a_out_tag), 64'(0));
    check_eq("rst_a_done_cnt", 64'(a_done_cnt), 64'(0));
    check_eq("rst_a_in_ready", 64'(a_in_ready), 64'(1));
    check_eq("rst_b_out_valid", 64'(b_out_valid), 64'(0));
    check_eq("rst_b_done_cnt", 64'(b_done_cnt), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // B: small products, approx dropping LL, latency and 2-bit counter wrap
    for (int i = 0; i < 5; i++) run_b(ta[i], tb[i], tap[i], tt[i], tp[i], tc[i]);

    // A: back-to-back stream of 8 beats against a 1,0,0 ready pattern
    pat_cnt  = 0;
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      ra  = 8'(i * 37 + 5);
      rb  = 8'(255 - i * 11);
      rap = 1'(i % 2);
      a_send(ra, rb, rap, 4'(i), model_a(ra, rb, rap));
    end
    a_idle();
    a_drain();
    check_eq("a_done_cnt_8", 64'(a_done_cnt), 64'(8));

    // A: corner operands
    rdy_mode = 0;
    a_send(8'd255, 8'd255, 1'b0, 4'd1, 16'd65025);
    a_send(8'd255, 8'd255, 1'b1, 4'd2, 16'd64976);
    a_send(8'd0, 8'd255, 1'b0, 4'd3, 16'd0);
    a_idle();
    a_drain();

    // A: random operands, random gaps, random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        a_idle();
        @(posedge clk);
        #1;
      end
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rap = 1'($urandom_range(0, 1));
      rt  = 4'($urandom_range(0, 15));
      a_send(ra, rb, rap, rt, model_a(ra, rb, rap));
    end
    a_idle();
    a_drain();
    check_eq("a_done_cnt_total", 64'(a_done_cnt), 64'(16'(a_retired)));

    // A: reset with three beats in flight; none may come out afterwards
    rdy_mode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) a_send(8'(100 + i), 8'(50 + i), 1'b0, 4'(9 + i), 16'd0);
    a_idle();
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("flush_out_valid", 64'(a_out_valid), 64'(0));
    check_eq("flush_out_p", 64'(a_out_p), 64'(0));
    check_eq("flush_out_tag", 64'(a_out_tag), 64'(0));
    check_eq("flush_done_cnt", 64'(a_done_cnt), 64'(0));
    check_eq("flush_in_ready", 64'(a_in_ready), 64'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_eq("flush_no_emerge", 64'(a_out_valid), 64'(0));
    end
    check_eq("flush_done_cnt_after", 64'(a_done_cnt), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
